// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Packs symbolic MIPS instructions (kind, rs, rt, rd, imm) into 32-bit R-type
// or I-type words, buffers them in a DEPTH-entry FIFO and writes them
// sequentially into instruction memory starting at word address 0.
//
// Supported kinds: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor,
// 8 slt, 9 sltu, 10 lw, 11 sw, 12 beq. Kinds 13-15 are illegal.
//
// Configuration macro: ENCODER_ILLEGAL_TRAP_EN
//   defined   : illegal kinds are accepted, nothing is pushed, err is set.
//   undefined : illegal kinds are encoded as NOP (32'h0) and written normally.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous flush of FIFO, address, count and flags
//   in_valid/in_ready   input handshake; in_ready = FIFO not full
//   in_kind/rs/rt/rd/imm  instruction fields
//   mem_we/mem_ready    write handshake; mem_we = FIFO not empty
//   mem_addr, mem_wdata current write address and FIFO head word
//   word_count          words written, saturating at all-ones
//   wrapped             sticky: mem_addr wrapped from max to 0
//   err                 sticky: illegal kind trapped
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              wrapped,
  output logic              err
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   WCNT_MAX = '1;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,  K_ADDU = 4'd1,  K_SUB = 4'd2, K_SUBU = 4'd3,
    K_AND  = 4'd4,  K_OR   = 4'd5,  K_XOR = 4'd6, K_NOR  = 4'd7,
    K_SLT  = 4'd8,  K_SLTU = 4'd9,  K_LW  = 4'd10, K_SW  = 4'd11,
    K_BEQ  = 4'd12
  } kind_e;

  // -------------------------------------------------------------------------
  // Encoder
  // -------------------------------------------------------------------------
  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic        is_r;
  logic        kind_legal;
  logic [31:0] enc_word;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned (which would infer a latch).
    funct      = 6'h00;
    opcode     = 6'h00;
    is_r       = 1'b1;
    kind_legal = 1'b1;
    case (in_kind)
      K_ADD:  funct = 6'h20;
      K_ADDU: funct = 6'h21;
      K_SUB:  funct = 6'h22;
      K_SUBU: funct = 6'h23;
      K_AND:  funct = 6'h24;
      K_OR:   funct = 6'h25;
      K_XOR:  funct = 6'h26;
      K_NOR:  funct = 6'h27;
      K_SLT:  funct = 6'h2a;
      K_SLTU: funct = 6'h2b;
      K_LW:   begin is_r = 1'b0; opcode = 6'h23; end
      K_SW:   begin is_r = 1'b0; opcode = 6'h2b; end
      K_BEQ:  begin is_r = 1'b0; opcode = 6'h04; end
      default: kind_legal = 1'b0;
    endcase

    if (!kind_legal)
      enc_word = 32'h0000_0000;                      // NOP
    else if (is_r)
      enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, funct};
    else
      enc_word = {opcode, in_rs, in_rt, in_imm};
  end

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    cnt_q,    cnt_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [ADDR_W:0]   wcnt_q,   wcnt_d;
  logic              wrapped_q, wrapped_d;
  logic              err_q,    err_d;
  logic [31:0]       fifo_q [DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic err_set;

  assign in_ready = (cnt_q != FULL_CNT);
  assign mem_we   = (cnt_q != '0);
  assign accept   = in_valid && in_ready;
  assign pop      = mem_we && mem_ready;

`ifdef ENCODER_ILLEGAL_TRAP_EN
  // Illegal kinds are consumed from the input but never reach memory.
  assign push    = accept && kind_legal;
  assign err_set = accept && !kind_legal;
`else
  assign push    = accept;
  assign err_set = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next state; clear overrides push and pop
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wcnt_d    = wcnt_q;
    wrapped_d = wrapped_q;
    err_d     = err_q;

    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      addr_d    = '0;
      wcnt_d    = '0;
      wrapped_d = 1'b0;
      err_d     = 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) wrapped_d = 1'b1;
        if (wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (err_set) err_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wcnt_q    <= '0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      wrapped_q <= wrapped_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, and mem_wdata is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (push && !clear) fifo_q[wr_ptr_q] <= enc_word;
  end

  assign mem_wdata  = mem_we ? fifo_q[rd_ptr_q] : 32'h0000_0000;
  assign mem_addr   = addr_q;
  assign word_count = wcnt_q;
  assign wrapped    = wrapped_q;
  assign err        = err_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder: the write-side counterpart of the single-cycle control decoder. It accepts symbolic instructions (kind, register numbers, immediate) over a valid/ready handshake and packs each into a 32-bit R-type or I-type word. Words are buffered in a small FIFO and written sequentially into instruction memory. Only the instruction subset the datapath decodes is supported: add, addu, sub, subu, and, or, xor, nor, slt, sltu, lw, sw, beq.

## Interface
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 4: FIFO depth in entries; must be a power of two, ≥2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of FIFO, address, count and flags.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept; high when FIFO not full.
- in_kind  in  4  0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 lw, 11 sw, 12 beq, 13–15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register numbers.
- in_imm  in  16  immediate or branch offset.
- mem_we  out  1  write request; high whenever FIFO non-empty.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word address of the current write.
- mem_wdata  out  32  encoded word at FIFO head.
- word_count  out  ADDR_W+1  words written; saturates at all-ones.
- wrapped  out  1  sticky: mem_addr wrapped from max back to 0.
- err  out  1  sticky: illegal kind seen (macro-dependent).

## Operation
- Accept occurs when in_valid && in_ready at a rising edge. The encoded word is pushed into the FIFO in the same edge.
- R-type (kinds 0–9): {6'h00, rs, rt, rd, 5'b0, funct}. funct values: 0x20, 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x27, 0x2a, 0x2b for kinds 0–9. in_imm is ignored.
- I-type: {opcode, rs, rt, imm}. Opcodes: lw 0x23, sw 0x2b, beq 0x04. in_rd is ignored.
- Drain occurs when mem_we && mem_ready. The FIFO pops, mem_addr increments modulo 2^ADDR_W, and word_count increments (saturating).
- When mem_addr increments from 2^ADDR_W−1 to 0, wrapped is set and stays set until clear or reset.
- mem_wdata and mem_addr are held stable while mem_we && !mem_ready.
- Simultaneous push and pop with the FIFO non-full: both occur and the occupancy is unchanged. When the FIFO is full, in_ready is low, so no push happens in that cycle (no bypass).
- clear has priority over push and pop. It empties the FIFO and zeroes mem_addr, word_count, wrapped and err.
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, word_count 0, wrapped 0, err 0, in_ready 1. Reset asserted mid-transfer discards the FIFO contents.

## Timing
- Latency: an instruction accepted at edge N drives mem_we/mem_wdata from edge N onward, so it is visible in cycle N+1 at the earliest.
- Throughput: one word per cycle with mem_ready held high.
- in_ready is combinational from FIFO occupancy only; it does not depend on in_valid.
- mem_we and mem_wdata are driven from the FIFO head registers; there is no combinational path from the in_* inputs.

## Configuration
- ENCODER_ILLEGAL_TRAP_EN defined: illegal kinds (13–15) are accepted, nothing is pushed, and err is set.
- Macro undefined: illegal kinds are encoded as NOP 0x00000000 and written normally; err stays 0.

## Test plan
- Reset, then add rs=1 rt=2 rd=3 with mem_ready=1 → one write of 0x00221820 at addr 0; word_count=1.
- lw rt=8 rs=29 imm=4, then sw rt=5 rs=0 imm=8, then beq rs=1 rt=2 imm=0xFFFF → writes 0x8FA80004, 0xAC050008, 0x1022FFFF at addrs 0, 1, 2.
- mem_ready=0, push 5 instructions with DEPTH=4 → in_ready drops after the 4th, mem_wdata stays at the first word; raising mem_ready drains the words in order.
- ADDR_W=2, write 5 words → addresses 0, 1, 2, 3, 0; wrapped=1 after the 4th write; word_count=5.
- kind=14 → with the macro: err=1 and no write; without the macro: a write of 0x00000000 and err=0.
- Assert clear (or rst_n=0) with 3 words queued → mem_we=0 next cycle, mem_addr=0, word_count=0, flags cleared.
